// File: rtl/gfx_fb_write_arb.sv
// gfx_fb_write_arb: owns the framebuffer write port, sequencing full-screen clears ahead of draw traffic
module gfx_fb_write_arb #(
    parameter int FB_WIDTH = 640,
    parameter int FB_HEIGHT = 480,
    parameter int PIXEL_BITS = 12,
    parameter int CLEAR_ON_RESET = 1,
    localparam int FB_X_BITS = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  clr_restart,
    output logic                  clr_inc,
    input  logic [FB_X_BITS-1:0]  clr_x,
    input  logic [FB_Y_BITS-1:0]  clr_y,
    input  logic [PIXEL_BITS-1:0] clr_color,
    input  logic                  clr_valid,
    input  logic                  clr_last,
    input  logic                  draw_valid,
    output logic                  draw_ready,
    input  logic [FB_X_BITS-1:0]  draw_x,
    input  logic [FB_Y_BITS-1:0]  draw_y,
    input  logic [PIXEL_BITS-1:0] draw_color,
    output logic                  fb_valid,
    input  logic                  fb_ready,
    output logic [FB_X_BITS-1:0]  fb_x,
    output logic [FB_Y_BITS-1:0]  fb_y,
    output logic [PIXEL_BITS-1:0] fb_color
);
    typedef enum logic [2:0] {RESTART, CLR_WAIT, CLEAR, DRAIN, DRAW} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? RESTART : DRAW;
    state_t state_q, state_d;
    logic pending_q, pending_d;
    logic fb_valid_q, fb_valid_d;
    logic clear_done_q, clear_done_d;
    logic [FB_X_BITS-1:0] fb_x_q, fb_x_d;
    logic [FB_Y_BITS-1:0] fb_y_q, fb_y_d;
    logic [PIXEL_BITS-1:0] fb_color_q, fb_color_d;
    logic free, take, draw_take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= RST_STATE;
            pending_q    <= 1'b0;
            fb_valid_q   <= 1'b0;
            clear_done_q <= 1'b0;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_color_q   <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            fb_valid_q   <= fb_valid_d;
            clear_done_q <= clear_done_d;
            fb_x_q       <= fb_x_d;
            fb_y_q       <= fb_y_d;
            fb_color_q   <= fb_color_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESTART:  state_d = CLR_WAIT;
            CLR_WAIT: state_d = clr_valid ? CLEAR : CLR_WAIT;
            CLEAR:    state_d = (take && clr_last) ? DRAW : CLEAR;
            DRAIN:    state_d = free ? RESTART : DRAIN;
            DRAW:     state_d = (pending_q || clear_req) ? DRAIN : DRAW;
            default:  state_d = RST_STATE;
        endcase
    end

    always_comb begin
        free         = !fb_valid_q || fb_ready;
        take         = (state_q == CLEAR) && clr_valid && free;
        draw_ready   = (state_q == DRAW) && !pending_q && free;
        draw_take    = draw_valid && draw_ready;
        clr_inc      = take;
        clr_restart  = (state_q == RESTART) && reset;
        clear_busy   = pending_q || (state_q != DRAW);
        pending_d    = (state_d == RESTART && state_q != RESTART) ? 1'b0 : (pending_q || clear_req);
        clear_done_d = take && clr_last;
        fb_valid_d   = free ? (take || draw_take) : 1'b1;
        fb_x_d       = take ? clr_x : draw_take ? draw_x : fb_x_q;
        fb_y_d       = take ? clr_y : draw_take ? draw_y : fb_y_q;
        fb_color_d   = take ? clr_color : draw_take ? draw_color : fb_color_q;
    end

    assign clear_done = clear_done_q;
    assign fb_valid   = fb_valid_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_color   = fb_color_q;
endmodule
